// File: rtl/test_fft.sv
`default_nettype none
//==============================================================================
// Module   : test_fft
// Purpose  : 8-point complex FFT/IFFT with burst I/O. Eight 24-bit complex
//            samples are loaded, transformed unscaled in three radix-2
//            decimation-in-time stages (one per clock), and unloaded as eight
//            28-bit complex bins in natural order.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            start, unload        - frame load / result unload requests
//            xn_re, xn_im         - input sample (signed 24-bit)
//            fwd_inv, fwd_inv_we  - direction config (1 = forward) + write enable
//            rfd, xn_index        - load window and index of sample accepted
//            busy, edone, done    - compute window, last compute cycle, ready pulse
//            dv, xk_index         - unload window and bin index
//            xk_re, xk_im         - output bin (signed 28-bit)
// Revision : 1.0 - initial release
//==============================================================================
module test_fft (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               unload,
    input  logic signed [23:0] xn_re,
    input  logic signed [23:0] xn_im,
    input  logic               fwd_inv,
    input  logic               fwd_inv_we,
    output logic               rfd,
    output logic [2:0]         xn_index,
    output logic               busy,
    output logic               edone,
    output logic               done,
    output logic               dv,
    output logic [2:0]         xk_index,
    output logic signed [27:0] xk_re,
    output logic signed [27:0] xk_im
);

    // sqrt(2)/2 in Q16 and the half-LSB used for round-half-up
    localparam logic signed [17:0] c_HALF_SQRT2 = 18'sd46341;
    localparam logic signed [47:0] c_RND_HALF   = 48'sd32768;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CALC   = 3'd2,
        S_READY  = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    // One counter serves as load index, stage number and unload index;
    // it restarts at 0 on every state change.
    logic [2:0]         r_cnt;
    logic               r_fwd_cfg;   // config register, 1 = forward
    logic               r_inv;       // direction frozen for the frame in flight
    logic               r_done;
    logic               w_enter_load;
    logic [2:0]         w_load_addr;

    // Working buffer: samples are stored bit-reversed so that in-place DIT
    // butterflies leave the bins in natural order.
    logic signed [27:0] r_re [8];
    logic signed [27:0] r_im [8];

    // Candidate buffer contents after each of the three stages
    logic signed [27:0] w_st_re [3][8];
    logic signed [27:0] w_st_im [3][8];
    logic signed [27:0] w_nx_re [8];
    logic signed [27:0] w_nx_im [8];

    //--------------------------------------------------------------------------
    // Arithmetic helpers
    //--------------------------------------------------------------------------
    // v * 46341 / 65536, rounded half-up (add 2^15, arithmetic shift by 16)
    function automatic logic signed [27:0] rnd_mul(input logic signed [29:0] v);
        logic signed [47:0] p;
        p = 48'(v) * 48'(c_HALF_SQRT2) + c_RND_HALF;
        return 28'(p >>> 16);
    endfunction

    // Multiply (a + jb) by W^k (forward) or conj(W^k) (inverse),
    // W = exp(-j*2*pi/8), k = 0..3. Returns {re, im}.
    // W^1 = c(1 - j), W^2 = -j, W^3 = c(-1 - j) with c = sqrt(2)/2;
    // the c-terms share one rounded product per output component.
    function automatic logic [55:0] twiddle(
        input logic signed [27:0] a,
        input logic signed [27:0] b,
        input logic [1:0]         k,
        input logic               inv
    );
        logic signed [29:0] s_sum;
        logic signed [29:0] s_dif;
        logic signed [27:0] t_re;
        logic signed [27:0] t_im;
        s_sum = 30'(a) + 30'(b);
        s_dif = 30'(a) - 30'(b);
        t_re  = a;
        t_im  = b;
        case (k)
            2'd0: begin
                t_re = a;
                t_im = b;
            end
            2'd1: begin
                if (!inv) begin
                    t_re = rnd_mul(s_sum);
                    t_im = rnd_mul(-s_dif);
                end else begin
                    t_re = rnd_mul(s_dif);
                    t_im = rnd_mul(s_sum);
                end
            end
            2'd2: begin
                if (!inv) begin
                    t_re = b;
                    t_im = -a;
                end else begin
                    t_re = -b;
                    t_im = a;
                end
            end
            default: begin
                if (!inv) begin
                    t_re = rnd_mul(-s_dif);
                    t_im = rnd_mul(-s_sum);
                end else begin
                    t_re = rnd_mul(-s_sum);
                    t_im = rnd_mul(s_dif);
                end
            end
        endcase
        return {t_re, t_im};
    endfunction

    //--------------------------------------------------------------------------
    // Butterfly network: stage s pairs elements H = 2^s apart; the twiddle
    // exponent is (position within the group) * 8 / (2H).
    //--------------------------------------------------------------------------
    generate
        for (genvar s = 0; s < 3; s++) begin : g_stage
            for (genvar bf = 0; bf < 4; bf++) begin : g_bfly
                localparam int         c_H   = 1 << s;
                localparam int         c_TOP = (bf / c_H) * (2 * c_H) + (bf % c_H);
                localparam int         c_BOT = c_TOP + c_H;
                localparam logic [1:0] c_K   = 2'((bf % c_H) * (4 >> s));

                logic [55:0] w_tw;

                assign w_tw = twiddle(r_re[c_BOT], r_im[c_BOT], c_K, r_inv);

                assign w_st_re[s][c_TOP] = r_re[c_TOP] + $signed(w_tw[55:28]);
                assign w_st_im[s][c_TOP] = r_im[c_TOP] + $signed(w_tw[27:0]);
                assign w_st_re[s][c_BOT] = r_re[c_TOP] - $signed(w_tw[55:28]);
                assign w_st_im[s][c_BOT] = r_im[c_TOP] - $signed(w_tw[27:0]);
            end
        end
    endgenerate

    // Select the stage that matches the current compute cycle
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_nx_re[i] = w_st_re[2][i];
            w_nx_im[i] = w_st_im[2][i];
            case (r_cnt)
                3'd0: begin
                    w_nx_re[i] = w_st_re[0][i];
                    w_nx_im[i] = w_st_im[0][i];
                end
                3'd1: begin
                    w_nx_re[i] = w_st_re[1][i];
                    w_nx_im[i] = w_st_im[1][i];
                end
                default: begin
                    w_nx_re[i] = w_st_re[2][i];
                    w_nx_im[i] = w_st_im[2][i];
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Control FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rfd         = 1'b0;
        busy        = 1'b0;
        edone       = 1'b0;
        dv          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                rfd = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == 3'd2) begin
                    edone       = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                // unload has priority; a start here discards the results
                if (unload) begin
                    w_state_nxt = S_UNLOAD;
                end else if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_UNLOAD: begin
                dv = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_enter_load = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    assign w_load_addr  = {r_cnt[0], r_cnt[1], r_cnt[2]};

    assign done     = r_done;
    assign xn_index = rfd ? r_cnt : 3'd0;
    assign xk_index = dv  ? r_cnt : 3'd0;
    assign xk_re    = dv  ? r_re[r_cnt] : 28'sd0;
    assign xk_im    = dv  ? r_im[r_cnt] : 28'sd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_fwd_cfg <= 1'b1;
            r_inv     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (fwd_inv_we) begin
                r_fwd_cfg <= fwd_inv;
            end
            // A write on the very edge that starts the frame already applies
            if (w_enter_load) begin
                r_inv <= fwd_inv_we ? ~fwd_inv : ~r_fwd_cfg;
            end
            r_done <= edone;
            if (w_state_nxt != r_state) begin
                r_cnt <= 3'd0;
            end else if ((r_state == S_LOAD) || (r_state == S_CALC) ||
                         (r_state == S_UNLOAD)) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Data buffer: sample capture during load, in-place update during compute
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_re[i] <= 28'sd0;
                r_im[i] <= 28'sd0;
            end
        end else if (r_state == S_LOAD) begin
            r_re[w_load_addr] <= {{4{xn_re[23]}}, xn_re};
            r_im[w_load_addr] <= {{4{xn_im[23]}}, xn_im};
        end else if (r_state == S_CALC) begin
            for (int i = 0; i < 8; i++) begin
                r_re[i] <= w_nx_re[i];
                r_im[i] <= w_nx_im[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_fft.sv
`default_nettype none
//==============================================================================
// Module   : tb_test_fft
// Purpose  : Directed self-checking bench for test_fft: reset state, simple
//            spectra with exact bins, rounding on a full-scale impulse,
//            forward/inverse phasor peaks, config timing, back-to-back frames
//            and asynchronous reset during compute and unload.
// Revision : 1.0 - initial release
//==============================================================================
module tb_test_fft;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               unload;
    logic signed [23:0] xn_re;
    logic signed [23:0] xn_im;
    logic               fwd_inv;
    logic               fwd_inv_we;
    logic               rfd;
    logic [2:0]         xn_index;
    logic               busy;
    logic               edone;
    logic               done;
    logic               dv;
    logic [2:0]         xk_index;
    logic signed [27:0] xk_re;
    logic signed [27:0] xk_im;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [23:0] in_re  [8];
    logic signed [23:0] in_im  [8];
    logic signed [27:0] res_re [8];
    logic signed [27:0] res_im [8];
    longint             exp_re [8];
    longint             exp_im [8];

    test_fft u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .unload     (unload),
        .xn_re      (xn_re),
        .xn_im      (xn_im),
        .fwd_inv    (fwd_inv),
        .fwd_inv_we (fwd_inv_we),
        .rfd        (rfd),
        .xn_index   (xn_index),
        .busy       (busy),
        .edone      (edone),
        .done       (done),
        .dv         (dv),
        .xk_index   (xk_index),
        .xk_re      (xk_re),
        .xk_im      (xk_im)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint iabs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic clear_frame();
        for (int n = 0; n < 8; n++) begin
            in_re[n]  = 24'sd0;
            in_im[n]  = 24'sd0;
            exp_re[n] = 0;
            exp_im[n] = 0;
        end
    endtask

    task automatic set_sample(input int n, input int re, input int im);
        in_re[n] = 24'(re);
        in_im[n] = 24'(im);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".rfd"},      rfd,      0);
        check({tag, ".busy"},     busy,     0);
        check({tag, ".edone"},    edone,    0);
        check({tag, ".done"},     done,     0);
        check({tag, ".dv"},       dv,       0);
        check({tag, ".xn_index"}, xn_index, 0);
        check({tag, ".xk_index"}, xk_index, 0);
        check({tag, ".xk_re"},    xk_re,    0);
        check({tag, ".xk_im"},    xk_im,    0);
    endtask

    // Starts from IDLE just after an edge; returns just after E8.
    task automatic load_frame(input string tag, input bit mid_we, input bit mid_val);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xn_re = in_re[i];
            xn_im = in_im[i];
            check($sformatf("%s.rfd%0d", tag, i), rfd, 1);
            check($sformatf("%s.xn_index%0d", tag, i), xn_index, i);
            if (mid_we && i == 3) begin
                fwd_inv    = mid_val;
                fwd_inv_we = 1'b1;
            end
            tick();
            fwd_inv_we = 1'b0;
        end
        xn_re = 24'sd0;
        xn_im = 24'sd0;
        check({tag, ".rfd_off"}, rfd, 0);
    endtask

    // Returns just after E11 (the done cycle).
    task automatic calc_phase(input string tag);
        check({tag, ".busy_c1"},  busy,  1);
        check({tag, ".edone_c1"}, edone, 0);
        tick();
        check({tag, ".busy_c2"},  busy,  1);
        tick();
        check({tag, ".busy_c3"},  busy,  1);
        check({tag, ".edone_c3"}, edone, 1);
        tick();
        check({tag, ".busy_rdy"},  busy,  0);
        check({tag, ".edone_rdy"}, edone, 0);
        check({tag, ".done"},      done,  1);
    endtask

    task automatic unload_frame(input string tag, input int delay);
        for (int d = 0; d < delay; d++) begin
            tick();
            check($sformatf("%s.done_hold%0d", tag, d), done, 0);
            check($sformatf("%s.dv_hold%0d", tag, d), dv, 0);
        end
        unload = 1'b1;
        tick();
        unload = 1'b0;
        check({tag, ".done_off"}, done, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.dv%0d", tag, i), dv, 1);
            check($sformatf("%s.xk_index%0d", tag, i), xk_index, i);
            res_re[i] = xk_re;
            res_im[i] = xk_im;
            tick();
        end
        check({tag, ".dv_off"},    dv,    0);
        check({tag, ".xk_re_off"}, xk_re, 0);
        check({tag, ".xk_im_off"}, xk_im, 0);
    endtask

    task automatic run_frame(input string tag, input int delay);
        load_frame(tag, 1'b0, 1'b0);
        calc_phase(tag);
        unload_frame(tag, delay);
    endtask

    task automatic check_bins(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s.X%0d.re", tag, k), res_re[k], exp_re[k]);
            check($sformatf("%s.X%0d.im", tag, k), res_im[k], exp_im[k]);
        end
    endtask

    // Phasor of amplitude 2^20: the peak bin is 8*2^20 real, others near 0.
    task automatic check_peak(input string tag, input int pk);
        for (int k = 0; k < 8; k++) begin
            longint tr;
            tr = (k == pk) ? 64'sd8388608 : 64'sd0;
            check($sformatf("%s.X%0d.re(%0d vs %0d+-64)", tag, k, res_re[k], tr),
                  (iabs(res_re[k] - tr) <= 64), 1);
            check($sformatf("%s.X%0d.im(%0d vs 0+-64)", tag, k, res_im[k]),
                  (iabs(res_im[k]) <= 64), 1);
        end
    endtask

    task automatic set_phasor();
        clear_frame();
        set_sample(0,  1048576,        0);
        set_sample(1,   741455,   741455);
        set_sample(2,        0,  1048576);
        set_sample(3,  -741455,   741455);
        set_sample(4, -1048576,        0);
        set_sample(5,  -741455,  -741455);
        set_sample(6,        0, -1048576);
        set_sample(7,   741455,  -741455);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached, expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        unload     = 1'b0;
        fwd_inv    = 1'b1;
        fwd_inv_we = 1'b0;
        xn_re      = 24'sd0;
        xn_im      = 24'sd0;
        clear_frame();
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        tick();

        // Constant 1+0j
        clear_frame();
        for (int n = 0; n < 8; n++) set_sample(n, 1, 0);
        exp_re[0] = 8;
        run_frame("const", 0);
        check_bins("const");

        // 2,0,2,0,... with a delayed unload (done must stay one cycle wide)
        clear_frame();
        for (int n = 0; n < 8; n += 2) set_sample(n, 2, 0);
        exp_re[0] = 8;
        exp_re[4] = 8;
        run_frame("alt20", 2);
        check_bins("alt20");

        // 0,2,0,2,...
        clear_frame();
        for (int n = 1; n < 8; n += 2) set_sample(n, 2, 0);
        exp_re[0] = 8;
        exp_re[4] = -8;
        run_frame("alt02", 0);
        check_bins("alt02");

        // Unit impulse at 0
        clear_frame();
        set_sample(0, 1, 0);
        for (int k = 0; k < 8; k++) exp_re[k] = 1;
        run_frame("imp0", 0);
        check_bins("imp0");

        // Full-scale impulse at 1: round((2^23-1)*46341/65536) = 5931647
        clear_frame();
        set_sample(1, 8388607, 0);
        exp_re[0] =  8388607; exp_im[0] =        0;
        exp_re[1] =  5931647; exp_im[1] = -5931647;
        exp_re[2] =        0; exp_im[2] = -8388607;
        exp_re[3] = -5931647; exp_im[3] = -5931647;
        exp_re[4] = -8388607; exp_im[4] =        0;
        exp_re[5] = -5931647; exp_im[5] =  5931647;
        exp_re[6] =        0; exp_im[6] =  8388607;
        exp_re[7] =  5931647; exp_im[7] =  5931647;
        run_frame("imp1", 0);
        check_bins("imp1");

        // Positive-frequency phasor, forward
        set_phasor();
        run_frame("ph_fwd", 0);
        check_peak("ph_fwd", 1);

        // Switch to inverse in a separate cycle
        fwd_inv    = 1'b0;
        fwd_inv_we = 1'b1;
        tick();
        fwd_inv_we = 1'b0;
        fwd_inv    = 1'b1;
        run_frame("ph_inv", 0);
        check_peak("ph_inv", 7);

        // Back to forward written mid-load: this frame is still inverse
        load_frame("ph_mid", 1'b1, 1'b1);
        calc_phase("ph_mid");
        unload_frame("ph_mid", 0);
        check_peak("ph_mid", 7);
        run_frame("ph_after", 0);
        check_peak("ph_after", 1);

        // start and unload held high: 21-cycle frames back to back
        xn_re  = 24'sd1;
        xn_im  = 24'sd0;
        start  = 1'b1;
        unload = 1'b1;
        for (int c = 0; c < 42; c++) begin
            int         p;
            logic [4:0] e;
            tick();
            p = c % 21;
            e = {(p < 8), (p >= 8 && p <= 10), (p == 10), (p == 11), (p >= 12 && p <= 19)};
            check($sformatf("b2b.c%0d.ctl", c), {rfd, busy, edone, done, dv}, e);
            if (p >= 12 && p <= 19) begin
                check($sformatf("b2b.c%0d.xk_re", c), xk_re, (p == 12) ? 8 : 0);
            end
        end
        start  = 1'b0;
        unload = 1'b0;
        xn_re  = 24'sd0;

        // Reset during compute, with inverse configured beforehand
        fwd_inv    = 1'b0;
        fwd_inv_we = 1'b1;
        tick();
        fwd_inv_we = 1'b0;
        fwd_inv    = 1'b1;
        set_phasor();
        load_frame("rcalc", 1'b0, 1'b0);
        tick();
        check("rcalc.busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("rcalc");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // config returned to forward
        run_frame("rcalc_fresh", 0);
        check_peak("rcalc_fresh", 1);

        // Reset during unload
        clear_frame();
        for (int n = 0; n < 8; n++) set_sample(n, 1, 0);
        exp_re[0] = 8;
        load_frame("runl", 1'b0, 1'b0);
        calc_phase("runl");
        unload = 1'b1;
        tick();
        unload = 1'b0;
        tick();
        tick();
        check("runl.dv_pre", dv, 1);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("runl");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame("runl_fresh", 0);
        check_bins("runl_fresh");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
